sdram_access_adapter: RTL

- Front-end stage directly upstream of the single-access SDRAM read/write engine (200 MHz domain, DE10-Lite 64 MB SDRAM, 16-bit bus).
- Accepts CPU-side byte-addressed load/store requests (byte/half/word/double) and translates each into an engine job: bank, row, column, first DQM and operation count, plus data swizzling in both directions.
- Enforces natural alignment.
- Gates jobs on SDRAM init completion.
- Runs the auto-refresh interval timer and inserts refresh slots only between jobs.

---
 rtl/sdram_access_adapter_pkg.sv | 32 +++
 rtl/sdram_access_adapter_refresh_timer.sv | 23 ++
 rtl/sdram_access_adapter.sv | 108 ++++++++++
 3 files changed

// File: rtl/sdram_access_adapter_pkg.sv
// sdram_access_adapter_pkg: size, DQM and state encodings plus the
// address-alignment and halfword swizzle helpers shared by the adapter.
package sdram_access_adapter_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_DOUBLE = 2'b11} size_e;
  typedef enum logic [2:0] {S_IDLE, S_REFRESH, S_ISSUE, S_DONE, S_ERR} state_e;
  localparam logic [1:0] DQM_ALL = 2'b00;
  localparam logic [1:0] DQM_UPPER = 2'b01;
  localparam logic [1:0] DQM_LOWER = 2'b10;
  localparam int REFRESH_CYCLES_DEFAULT = 1500;
  function automatic logic misaligned(input logic [2:0] addr, input logic [1:0] size);
    return size == SZ_HALF ? addr[0] : size == SZ_WORD ? |addr[1:0] : size == SZ_DOUBLE ? |addr : 1'b0;
  endfunction
  function automatic logic [1:0] dqm_code(input logic odd, input logic [1:0] size);
    return size == SZ_BYTE ? (odd ? DQM_UPPER : DQM_LOWER) : DQM_ALL;
  endfunction
  function automatic logic [2:0] op_count(input logic [1:0] size);
    return size == SZ_WORD ? 3'd1 : size == SZ_DOUBLE ? 3'd3 : 3'd0;
  endfunction
  // Lowest-addressed halfword goes out first, so it sits at the top of the engine word.
  function automatic logic [63:0] pack_write(input logic [63:0] d, input logic [1:0] size);
    return size == SZ_BYTE ? {d[7:0], 56'd0} :
           size == SZ_HALF ? {d[15:0], 48'd0} :
           size == SZ_WORD ? {d[15:0], d[31:16], 32'd0} :
                             {d[15:0], d[31:16], d[47:32], d[63:48]};
  endfunction
  function automatic logic [63:0] unpack_read(input logic [63:0] r, input logic [1:0] size);
    return size == SZ_BYTE ? {56'd0, r[7:0]} :
           size == SZ_HALF ? {48'd0, r[15:0]} :
           size == SZ_WORD ? {32'd0, r[15:0], r[31:16]} :
                             {r[15:0], r[31:16], r[47:32], r[63:48]};
  endfunction
endpackage

// File: rtl/sdram_access_adapter_refresh_timer.sv
// sdram_refresh_timer: saturating auto-refresh interval counter with a
// sticky pending flag, both cleared when the refresh sequencer acknowledges.
module sdram_refresh_timer #(
  parameter int REFRESH_CYCLES = 1500
) (
  input  logic clock,
  input  logic reset,
  input  logic refresh_ack,
  output logic pending
);
  localparam int W = REFRESH_CYCLES > 2 ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [W-1:0] LIMIT = W'(REFRESH_CYCLES - 1);
  logic [W-1:0] count;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      count <= '0;
      pending <= 1'b0;
    end else if (refresh_ack) begin
      count <= '0;
      pending <= 1'b0;
    end else if (count == LIMIT) pending <= 1'b1;
    else count <= count + 1'b1;
endmodule

// File: rtl/sdram_access_adapter.sv
// sdram_access_adapter: turns CPU byte-addressed loads/stores into single
// SDRAM engine jobs, with alignment checks, init gating and refresh slots.
module sdram_access_adapter
  import sdram_access_adapter_pkg::*;
#(
  parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEFAULT,
  parameter int ADDR_W = 26
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              init_done,
  input  logic              cpu_rd_en,
  input  logic              cpu_wr_en,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [1:0]        cpu_size,
  input  logic [63:0]       cpu_wr_data,
  output logic [63:0]       cpu_rd_data,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic              refresh_req,
  input  logic              refresh_ack,
  output logic              rw_rd_enable,
  output logic              rw_wr_enable,
  output logic [12:0]       rw_row,
  output logic [9:0]        rw_column,
  output logic [1:0]        rw_bank,
  output logic [1:0]        rw_dqm,
  output logic [2:0]        rw_op_num,
  input  logic              rw_end_op,
  input  logic [63:0]       rw_rd_data,
  output logic [63:0]       rw_wr_data
);
  state_e state;
  logic pending;
  logic req;
  logic bad;
  logic [1:0] job_size;
  assign req = cpu_rd_en | cpu_wr_en;
  assign bad = misaligned(cpu_addr[2:0], cpu_size);
  sdram_refresh_timer #(.REFRESH_CYCLES(REFRESH_CYCLES)) u_timer (
    .clock(clock),
    .reset(reset),
    .refresh_ack(refresh_ack),
    .pending(pending)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      job_size <= '0;
      cpu_rd_data <= '0;
      cpu_ack <= 1'b0;
      cpu_err <= 1'b0;
      refresh_req <= 1'b0;
      rw_rd_enable <= 1'b0;
      rw_wr_enable <= 1'b0;
      rw_row <= '0;
      rw_column <= '0;
      rw_bank <= '0;
      rw_dqm <= '0;
      rw_op_num <= '0;
      rw_wr_data <= '0;
    end else
      case (state)
        S_IDLE:
          if (pending && init_done) begin
            state <= S_REFRESH;
            refresh_req <= 1'b1;
          end else if (req && init_done && bad) begin
            state <= S_ERR;
            cpu_ack <= 1'b1;
            cpu_err <= 1'b1;
          end else if (req && init_done) begin
            state <= S_ISSUE;
            rw_rd_enable <= cpu_rd_en;
            rw_wr_enable <= !cpu_rd_en;
            rw_bank <= cpu_addr[ADDR_W-1 -: 2];
            rw_row <= cpu_addr[ADDR_W-3 -: 13];
            rw_column <= cpu_addr[10:1];
            rw_dqm <= dqm_code(cpu_addr[0], cpu_size);
            rw_op_num <= op_count(cpu_size);
            rw_wr_data <= pack_write(cpu_wr_data, cpu_size);
            job_size <= cpu_size;
          end
        S_REFRESH:
          if (refresh_ack) begin
            state <= S_IDLE;
            refresh_req <= 1'b0;
          end
        S_ISSUE:
          if (rw_end_op) begin
            state <= S_DONE;
            rw_rd_enable <= 1'b0;
            rw_wr_enable <= 1'b0;
            cpu_ack <= 1'b1;
            if (rw_rd_enable) cpu_rd_data <= unpack_read(rw_rd_data, job_size);
          end
        S_DONE: begin
          state <= S_IDLE;
          cpu_ack <= 1'b0;
        end
        S_ERR: begin
          state <= S_IDLE;
          cpu_ack <= 1'b0;
          cpu_err <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
endmodule
